// File: rtl/md5_pkg.sv
// Shared MD5 constants, round helpers and the engine FSM state type.
// Everything here is pure combinational lookup and can be used in any context.
package md5_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FINAL,
        ST_DONE
    } md5_state_t;

    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hefcdab89;
    localparam logic [31:0] IV_C = 32'h98badcfe;
    localparam logic [31:0] IV_D = 32'h10325476;

    localparam logic [31:0] K_TABLE [0:63] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Message word index; the low four step bits suffice because 16*k vanishes mod 16.
    function automatic logic [3:0] g_index(input logic [5:0] idx);
        logic [3:0] i4;
        logic [3:0] g;
        i4 = idx[3:0];
        case (idx[5:4])
            2'd0:    g = i4;
            2'd1:    g = i4 * 4'd5 + 4'd1;
            2'd2:    g = i4 * 4'd3 + 4'd5;
            default: g = i4 * 4'd7;
        endcase
        return g;
    endfunction

    function automatic logic [4:0] shift_amt(input logic [5:0] idx);
        logic [4:0] s;
        case ({idx[5:4], idx[1:0]})
            4'h0: s = 5'd7;   4'h1: s = 5'd12;  4'h2: s = 5'd17;  4'h3: s = 5'd22;
            4'h4: s = 5'd5;   4'h5: s = 5'd9;   4'h6: s = 5'd14;  4'h7: s = 5'd20;
            4'h8: s = 5'd4;   4'h9: s = 5'd11;  4'ha: s = 5'd16;  4'hb: s = 5'd23;
            4'hc: s = 5'd6;   4'hd: s = 5'd10;  4'he: s = 5'd15;  default: s = 5'd21;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] md5_func(input logic [5:0] idx, input logic [31:0] b,
                                             input logic [31:0] c, input logic [31:0] d);
        logic [31:0] f;
        case (idx[5:4])
            2'd0:    f = (b & c) | (~b & d);
            2'd1:    f = (b & d) | (c & ~d);
            2'd2:    f = b ^ c ^ d;
            default: f = c ^ (b | ~d);
        endcase
        return f;
    endfunction

endpackage

// File: rtl/md5_step.sv
// One combinational MD5 step; the core chains several of these per clock.
module md5_step
    import md5_pkg::*;
(
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic [31:0] c_in,
    input  logic [31:0] d_in,
    input  logic [31:0] m_word,
    input  logic [5:0]  step_idx,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [31:0] c_out,
    output logic [31:0] d_out
);

    logic [31:0] sum;
    logic [31:0] rot;
    logic [4:0]  s;

    always_comb begin
        sum = a_in + md5_func(step_idx, b_in, c_in, d_in) + K_TABLE[step_idx] + m_word;
        s   = shift_amt(step_idx);
        // Shift amounts are never zero, so the right shift never reaches 32.
        rot = (sum << s) | (sum >> (6'd32 - {1'b0, s}));
    end

    assign a_out = d_in;
    assign b_out = b_in + rot;
    assign c_out = b_in;
    assign d_out = c_in;

endmodule

// File: rtl/md5_iter_core.sv
// Iterative MD5 compression of one 512-bit block with chaining IV, stall and target compare.
// ROUNDS_PER_CYCLE steps are evaluated per enabled clock by a chain of md5_step instances.
module md5_iter_core
    import md5_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int COMPARE_EN       = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] mesg,
    input  logic         chain,
    input  logic [127:0] iv,
    input  logic [127:0] target,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] digest,
    output logic         match
);

    localparam int R = ROUNDS_PER_CYCLE;

    if (!(R == 1 || R == 2 || R == 4 || R == 8 || R == 16)) begin : g_bad_rounds
        $error("md5_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    md5_state_t   state_reg, state_next;
    logic [5:0]   step_reg;
    logic [31:0]  msg_reg [16];
    logic [31:0]  a_reg, b_reg, c_reg, d_reg;
    logic [31:0]  iv_a_reg, iv_b_reg, iv_c_reg, iv_d_reg;
    logic [127:0] target_reg;
    logic [127:0] digest_reg;
    logic         out_valid_reg;
    logic         match_reg;

    logic         accept;
    logic         last_step;
    logic [31:0]  ca [R+1];
    logic [31:0]  cb [R+1];
    logic [31:0]  cc [R+1];
    logic [31:0]  cd [R+1];
    logic [127:0] digest_final;

    assign in_ready  = (state_reg == ST_IDLE) && !reset;
    assign accept    = en && in_valid && in_ready;
    assign last_step = (step_reg == 6'(64 - R));

    assign ca[0] = a_reg;
    assign cb[0] = b_reg;
    assign cc[0] = c_reg;
    assign cd[0] = d_reg;

    for (genvar gi = 0; gi < R; gi++) begin : g_step
        logic [5:0] step_idx;
        assign step_idx = step_reg + 6'(gi);
        md5_step u_step (
            .a_in    (ca[gi]),
            .b_in    (cb[gi]),
            .c_in    (cc[gi]),
            .d_in    (cd[gi]),
            .m_word  (msg_reg[g_index(step_idx)]),
            .step_idx(step_idx),
            .a_out   (ca[gi+1]),
            .b_out   (cb[gi+1]),
            .c_out   (cc[gi+1]),
            .d_out   (cd[gi+1])
        );
    end

    assign digest_final = {bswap32(a_reg + iv_a_reg), bswap32(b_reg + iv_b_reg),
                           bswap32(c_reg + iv_c_reg), bswap32(d_reg + iv_d_reg)};

    always_ff @(posedge clk) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (en) begin
            case (state_reg)
                ST_IDLE:  if (accept) state_next = ST_RUN;
                ST_RUN:   if (last_step) state_next = ST_FINAL;
                ST_FINAL: state_next = ST_DONE;
                ST_DONE:  if (out_ready) state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step_reg      <= '0;
            out_valid_reg <= 1'b0;
            digest_reg    <= '0;
            match_reg     <= 1'b0;
        end else if (en) begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        for (int j = 0; j < 16; j++) msg_reg[j] <= bswap32(mesg[511 - 32*j -: 32]);
                        target_reg <= target;
                        step_reg   <= '0;
                        a_reg      <= chain ? bswap32(iv[127:96]) : IV_A;
                        b_reg      <= chain ? bswap32(iv[95:64])  : IV_B;
                        c_reg      <= chain ? bswap32(iv[63:32])  : IV_C;
                        d_reg      <= chain ? bswap32(iv[31:0])   : IV_D;
                        iv_a_reg   <= chain ? bswap32(iv[127:96]) : IV_A;
                        iv_b_reg   <= chain ? bswap32(iv[95:64])  : IV_B;
                        iv_c_reg   <= chain ? bswap32(iv[63:32])  : IV_C;
                        iv_d_reg   <= chain ? bswap32(iv[31:0])   : IV_D;
                    end
                end
                ST_RUN: begin
                    a_reg    <= ca[R];
                    b_reg    <= cb[R];
                    c_reg    <= cc[R];
                    d_reg    <= cd[R];
                    step_reg <= step_reg + 6'(R);
                end
                ST_FINAL: begin
                    digest_reg    <= digest_final;
                    match_reg     <= (COMPARE_EN != 0) && (digest_final == target_reg);
                    out_valid_reg <= 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) out_valid_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign digest    = digest_reg;
    assign match     = match_reg;

endmodule

// File: tb/tb_md5_iter_core.sv
// Directed bench for md5_iter_core: three instances (1, 4, 16 steps/clock) checked against
// published MD5 digests, plus stall, backpressure, target-mismatch and reset-abort sequences.
module tb_md5_iter_core;

    localparam int RPC [3] = '{1, 4, 16};
    localparam int NV = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [511:0] mesg;
    logic         chain;
    logic [127:0] iv;
    logic [127:0] target;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] digest    [3];
    logic         match     [3];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        md5_iter_core #(.ROUNDS_PER_CYCLE(RPC[gi]), .COMPARE_EN(1)) u_dut (
            .clk      (clk),
            .reset    (reset),
            .en       (en),
            .in_valid (in_valid[gi]),
            .in_ready (in_ready[gi]),
            .mesg     (mesg),
            .chain    (chain),
            .iv       (iv),
            .target   (target),
            .out_valid(out_valid[gi]),
            .out_ready(out_ready[gi]),
            .digest   (digest[gi]),
            .match    (match[gi])
        );
    end

    typedef struct {
        logic [639:0] msg;
        int           len;
        int           inst;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [NV];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input int id, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %h, want %h", name, id, act, exp);
    endtask

    // MD5 padding: message bytes, 0x80, zeros, 64-bit little-endian bit length in the last block.
    function automatic logic [511:0] build_block(input logic [639:0] msg, input int len, input int blk);
        logic [511:0] b;
        logic [63:0]  bits;
        logic [7:0]   by;
        int           nblk;
        int           p;
        b    = '0;
        bits = 64'(len) * 64'd8;
        nblk = (len + 8) / 64 + 1;
        for (int k = 0; k < 64; k++) begin
            p  = blk * 64 + k;
            by = 8'h00;
            if (p < len)                        by = msg[8*(len-1-p) +: 8];
            else if (p == len)                  by = 8'h80;
            else if (blk == nblk - 1 && k >= 56) by = 8'(bits >> (8*(k-56)));
            b[511 - 8*k -: 8] = by;
        end
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_block(input int k, input logic [511:0] blk, input logic chn,
                                input logic [127:0] ivv, input logic [127:0] tgt);
        int n;
        mesg        = blk;
        chain       = chn;
        iv          = ivv;
        target      = tgt;
        in_valid[k] = 1'b1;
        n = 0;
        while (!in_ready[k] && n < 100) begin
            tick();
            n++;
        end
        tick();
        in_valid[k] = 1'b0;
        // Scramble inputs so results depend only on what was latched at acceptance.
        mesg   = {16{$urandom}};
        iv     = {4{$urandom}};
        target = {4{$urandom}};
        chain  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_result(input int k, input bit rand_en, output int lat);
        int   n;
        logic e;
        lat = 0;
        n   = 0;
        while (!out_valid[k] && n < 2000) begin
            if (rand_en) en = 1'($urandom_range(0, 1));
            e = en;
            tick();
            if (e) lat++;
            n++;
        end
        en = 1'b1;
    endtask

    task automatic release_out(input int k);
        out_ready[k] = 1'b1;
        tick();
        out_ready[k] = 1'b0;
    endtask

    task automatic run_msg(input int id, input logic [639:0] msg, input int len, input int k,
                           input logic [127:0] exp, input bit rand_en);
        int           nblk;
        int           lat;
        logic [127:0] dig;
        logic         mt;
        nblk = (len + 8) / 64 + 1;
        dig  = '0;
        mt   = 1'b0;
        for (int b = 0; b < nblk; b++) begin
            accept_block(k, build_block(msg, len, b), b > 0, dig, exp);
            wait_result(k, rand_en, lat);
            check("latency", id, 128'(lat), 128'(64 / RPC[k] + 1));
            dig = digest[k];
            mt  = match[k];
            release_out(k);
        end
        check("digest", id, dig, exp);
        check("match", id, 128'(mt), 128'd1);
    endtask

    initial begin
        int           lat;
        logic [127:0] d0;
        logic         m0;
        logic         ok;

        vecs[0] = '{msg: "The quick brown fox jumps over the lazy dog", len: 43, inst: 0, exp: 128'h9e107d9d372bb6826bd81d3542a419d6};
        vecs[1] = '{msg: "", len: 0, inst: 2, exp: 128'hd41d8cd98f00b204e9800998ecf8427e};
        vecs[2] = '{msg: "abc", len: 3, inst: 1, exp: 128'h900150983cd24fb0d6963f7d28e17f72};
        vecs[3] = '{msg: "message digest", len: 14, inst: 2, exp: 128'hf96b697d7cb7938d525a2f31aaf161d0};
        vecs[4] = '{msg: "abcdefghijklmnopqrstuvwxyz", len: 26, inst: 0, exp: 128'hc3fcd3d76192e4007dfb496cca67e13b};
        vecs[5] = '{msg: "12345678901234567890123456789012345678901234567890123456789012345678901234567890", len: 80, inst: 0, exp: 128'h57edf4a22be3c955ac49da2e2107b67a};
        vecs[6] = '{msg: "12345678901234567890123456789012345678901234567890123456789012345678901234567890", len: 80, inst: 1, exp: 128'h57edf4a22be3c955ac49da2e2107b67a};
        vecs[7] = '{msg: "12345678901234567890123456789012345678901234567890123456789012345678901234567890", len: 80, inst: 2, exp: 128'h57edf4a22be3c955ac49da2e2107b67a};
        vecs[8] = '{msg: "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789", len: 62, inst: 1, exp: 128'hd174ab98d277d9f5a5611c2c9f419d9f};
        vecs[9] = '{msg: "a", len: 1, inst: 2, exp: 128'h0cc175b9c0f1b6a831c399e269772661};

        reset  = 1'b1;
        en     = 1'b1;
        mesg   = '0;
        chain  = 1'b0;
        iv     = '0;
        target = '0;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
        end

        // Reset state
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            check("rst_in_ready", k, 128'(in_ready[k]), 128'd0);
            check("rst_out_valid", k, 128'(out_valid[k]), 128'd0);
            check("rst_digest", k, digest[k], 128'd0);
            check("rst_match", k, 128'(match[k]), 128'd0);
        end
        reset = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) check("idle_in_ready", k, 128'(in_ready[k]), 128'd1);

        // A handshake offered while en=0 must not be taken
        en          = 1'b0;
        in_valid[2] = 1'b1;
        repeat (3) tick();
        check("stall_no_accept", 2, 128'(in_ready[2]), 128'd1);
        in_valid[2] = 1'b0;
        en          = 1'b1;

        for (int vi = 0; vi < NV; vi++)
            run_msg(vi, vecs[vi].msg, vecs[vi].len, vecs[vi].inst, vecs[vi].exp, 1'b0);

        // Target mismatch on the empty-message block
        accept_block(2, build_block(vecs[1].msg, 0, 0), 1'b0, '0, vecs[1].exp ^ 128'd1);
        wait_result(2, 1'b0, lat);
        check("mm_digest", 20, digest[2], vecs[1].exp);
        check("mm_match", 20, 128'(match[2]), 128'd0);
        release_out(2);

        // Random en during RUN: latency counts enabled cycles only
        run_msg(30, vecs[0].msg, vecs[0].len, 0, vecs[0].exp, 1'b1);
        run_msg(31, vecs[5].msg, vecs[5].len, 1, vecs[5].exp, 1'b1);

        // Backpressure: result held 20 cycles, new offers ignored, then back-to-back block
        accept_block(1, build_block(vecs[2].msg, 3, 0), 1'b0, '0, vecs[2].exp);
        wait_result(1, 1'b0, lat);
        d0 = digest[1];
        m0 = match[1];
        check("bp_digest", 40, d0, vecs[2].exp);
        in_valid[1] = 1'b1;
        ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            mesg = {16{$urandom}};
            tick();
            if (digest[1] !== d0 || match[1] !== m0 || in_ready[1] !== 1'b0 || out_valid[1] !== 1'b1) ok = 1'b0;
        end
        check("bp_stable", 40, 128'(ok), 128'd1);
        in_valid[1] = 1'b0;
        release_out(1);
        check("bp_in_ready", 40, 128'(in_ready[1]), 128'd1);
        check("bp_out_valid", 40, 128'(out_valid[1]), 128'd0);
        run_msg(41, vecs[3].msg, vecs[3].len, 1, vecs[3].exp, 1'b0);

        // Reset at step 30 aborts the block
        accept_block(0, build_block(vecs[0].msg, 43, 0), 1'b0, '0, vecs[0].exp);
        repeat (30) tick();
        reset = 1'b1;
        tick();
        check("abort_in_ready", 50, 128'(in_ready[0]), 128'd0);
        reset = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (out_valid[0] !== 1'b0) ok = 1'b1;
        end
        check("abort_no_output", 50, 128'(ok), 128'd0);
        check("abort_digest", 50, digest[0], 128'd0);
        check("abort_in_ready_after", 50, 128'(in_ready[0]), 128'd1);
        run_msg(51, vecs[4].msg, vecs[4].len, 0, vecs[4].exp, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
